// File: rtl/axis_i2c_pkg.sv
// Shared constants and FSM state type for the AXI-Stream to i2c_master command bridge.
package axis_i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  // One i2c_master command FIFO word: {addr, data}
  localparam int CMD_W  = ADDR_W + DATA_W;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2
  } state_e;

endpackage

// File: rtl/axis_i2c_cmd.sv
// Converts AXI-Stream packets (address beat, then payload beats) into i2c_master FIFO pushes.
// Optional error counter output err_cnt is built when AXIS_I2C_CMD_ERRCNT_EN is defined.
module axis_i2c_cmd #(
  parameter int DATA_W = axis_i2c_pkg::DATA_W,
  parameter int ADDR_W = axis_i2c_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  output logic              busy
`ifdef AXIS_I2C_CMD_ERRCNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  import axis_i2c_pkg::*;

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_wr_en;
  logic              w_tready;
  logic              w_upper_zero;
  logic              w_addr_ld;
  logic              w_wr_set;
  logic              w_err;

  assign w_upper_zero = ((s_axis_tdata >> ADDR_W) == '0);

  always_comb begin
    w_state_next = r_state;
    w_tready     = 1'b0;
    w_addr_ld    = 1'b0;
    w_wr_set     = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_ADDR: begin
        w_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tlast) begin
            w_err = 1'b1;
          end else if (w_upper_zero) begin
            w_addr_ld    = 1'b1;
            w_state_next = S_DATA;
          end else begin
            w_err        = 1'b1;
            w_state_next = S_DROP;
          end
        end
      end
      S_DATA: begin
        // Blocking while a push is in flight caps the rate at one command per two cycles
        w_tready = !fifo_full && !r_wr_en;
        if (s_axis_tvalid && w_tready) begin
          w_wr_set = 1'b1;
          if (s_axis_tlast) begin
            w_state_next = S_ADDR;
          end
        end
      end
      S_DROP: begin
        w_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          w_state_next = S_ADDR;
        end
      end
      default: begin
        w_state_next = S_ADDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state <= S_ADDR;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wr_en <= w_wr_set;
      if (w_addr_ld) begin
        r_addr <= s_axis_tdata[ADDR_W-1:0];
      end
      if (w_wr_set) begin
        r_data <= s_axis_tdata;
      end
    end
  end

`ifdef AXIS_I2C_CMD_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_err_cnt <= '0;
    end else if (w_err && (r_err_cnt != ERR_CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  // Reset masks the handshake and any push still in flight so an abandoned packet never escapes
  assign s_axis_tready = w_tready && !arst;
  assign fifo_wr_en    = r_wr_en && !arst;
  assign addr          = r_addr;
  assign data          = r_data;
  assign busy          = (r_state != S_ADDR);

endmodule

// File: tb/tb_axis_i2c_cmd.sv
// Directed self-checking bench for axis_i2c_cmd; define AXIS_I2C_CMD_ERRCNT_EN to also check err_cnt.
module tb_axis_i2c_cmd;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              arst;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              fifo_wr_en;
  logic              fifo_full;
  logic              busy;
`ifdef AXIS_I2C_CMD_ERRCNT_EN
  logic [15:0]       err_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];
  int                wr_cyc_q[$];
  logic              full_prev = 1'b0;

  axis_i2c_cmd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .arst          (arst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .addr          (addr),
    .data          (data),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_full     (fifo_full),
    .busy          (busy)
`ifdef AXIS_I2C_CMD_ERRCNT_EN
    ,
    .err_cnt       (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: logs every push and checks it never follows a full cycle
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(data);
      wr_cyc_q.push_back(cyc);
      $display("write addr=0x%h data=0x%h cyc=%0d", addr, data, cyc);
      n_vec++;
      if (full_prev !== 1'b0) begin
        $display("FAIL wr_after_full: fifo_wr_en=1 after fifo_full=%b, required none", full_prev);
        n_err++;
      end
    end
    full_prev = fifo_full;
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge
  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last, output int hs);
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_axis_tready === 1'b1) begin
        hs = cyc;
        $display("beat tdata=0x%h tlast=%b cyc=%0d", d, last, hs);
        @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL handshake_timeout: tdata=0x%h not accepted in 50 cycles, required acceptance", d);
    n_vec++;
    n_err++;
    hs = -1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst          = 1'b1;
    fifo_full     = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h55;
    s_axis_tlast  = 1'b0;
    @(negedge clk);
    n_vec++;
    if (s_axis_tready !== 1'b0) begin
      $display("FAIL reset_tready: got %b, required 0", s_axis_tready); n_err++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (addr !== 7'h00) begin $display("FAIL reset_addr: got 0x%h, required 0x00", addr); n_err++; end
    n_vec++;
    if (data !== 8'h00) begin $display("FAIL reset_data: got 0x%h, required 0x00", data); n_err++; end
    n_vec++;
    if (fifo_wr_en !== 1'b0) begin $display("FAIL reset_wr_en: got %b, required 0", fifo_wr_en); n_err++; end
    n_vec++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b, required 0", busy); n_err++; end
`ifdef AXIS_I2C_CMD_ERRCNT_EN
    n_vec++;
    if (err_cnt !== 16'd0) begin $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt); n_err++; end
`endif
    @(posedge clk); #1;
    arst          = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (s_axis_tready !== 1'b1) begin
      $display("FAIL idle_tready: got %b, required 1", s_axis_tready); n_err++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    int hs;
    clear_log();
    send_beat(8'h50, 1'b0, hs);
    s_axis_tvalid = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin $display("FAIL single_busy: got %b, required 1", busy); n_err++; end
    send_beat(8'hA5, 1'b1, hs);
    idle(4);
    n_vec++;
    if (wr_addr_q.size() != 1) begin
      $display("FAIL single_count: got %0d writes, required 1", wr_addr_q.size()); n_err++;
    end else begin
      n_vec++;
      if (wr_addr_q[0] !== 7'h50) begin $display("FAIL single_addr: got 0x%h, required 0x50", wr_addr_q[0]); n_err++; end
      n_vec++;
      if (wr_data_q[0] !== 8'hA5) begin $display("FAIL single_data: got 0x%h, required 0xA5", wr_data_q[0]); n_err++; end
      n_vec++;
      if (wr_cyc_q[0] != hs + 1) begin $display("FAIL single_latency: got cyc %0d, required %0d", wr_cyc_q[0], hs + 1); n_err++; end
    end
    n_vec++;
    if (busy !== 1'b0) begin $display("FAIL single_busy_end: got %b, required 0", busy); n_err++; end
  endtask

  task automatic test_back_to_back();
    int hs;
    int hs_first;
    logic [DATA_W-1:0] exp_d[3];
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
    clear_log();
    send_beat(8'h3C, 1'b0, hs);
    send_beat(8'h01, 1'b0, hs_first);
    send_beat(8'h02, 1'b0, hs);
    send_beat(8'h03, 1'b1, hs);
    idle(4);
    n_vec++;
    if (wr_addr_q.size() != 3) begin
      $display("FAIL b2b_count: got %0d writes, required 3", wr_addr_q.size()); n_err++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (wr_data_q[i] !== exp_d[i] || wr_addr_q[i] !== 7'h3C) begin
          $display("FAIL b2b_write%0d: got addr=0x%h data=0x%h, required addr=0x3C data=0x%h",
                   i, wr_addr_q[i], wr_data_q[i], exp_d[i]);
          n_err++;
        end
      end
      n_vec++;
      if (wr_cyc_q[0] != hs_first + 1) begin
        $display("FAIL b2b_latency: got cyc %0d, required %0d", wr_cyc_q[0], hs_first + 1); n_err++;
      end
      n_vec++;
      if (wr_cyc_q[1] - wr_cyc_q[0] != 2 || wr_cyc_q[2] - wr_cyc_q[1] != 2) begin
        $display("FAIL b2b_spacing: got gaps %0d/%0d, required 2/2",
                 wr_cyc_q[1] - wr_cyc_q[0], wr_cyc_q[2] - wr_cyc_q[1]);
        n_err++;
      end
    end
  endtask

  task automatic test_backpressure();
    int hs;
    logic saw_ready;
    clear_log();
    send_beat(8'h10, 1'b0, hs);
    fifo_full     = 1'b1;
    s_axis_tdata  = 8'h55;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    saw_ready     = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (s_axis_tready !== 1'b0) saw_ready = 1'b1;
    end
    @(posedge clk); #1;
    n_vec++;
    if (saw_ready !== 1'b0) begin $display("FAIL bp_tready: got 1 while full, required 0"); n_err++; end
    n_vec++;
    if (wr_addr_q.size() != 0) begin
      $display("FAIL bp_no_write: got %0d writes while full, required 0", wr_addr_q.size()); n_err++;
    end
    fifo_full = 1'b0;
    send_beat(8'h55, 1'b1, hs);
    idle(4);
    n_vec++;
    if (wr_addr_q.size() != 1) begin
      $display("FAIL bp_resume_count: got %0d writes, required 1", wr_addr_q.size()); n_err++;
    end else begin
      n_vec++;
      if (wr_addr_q[0] !== 7'h10 || wr_data_q[0] !== 8'h55 || wr_cyc_q[0] != hs + 1) begin
        $display("FAIL bp_resume_write: got addr=0x%h data=0x%h cyc=%0d, required addr=0x10 data=0x55 cyc=%0d",
                 wr_addr_q[0], wr_data_q[0], wr_cyc_q[0], hs + 1);
        n_err++;
      end
    end
  endtask

  task automatic test_errors();
    int hs;
    clear_log();
    send_beat(8'h80, 1'b0, hs);
    s_axis_tvalid = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin $display("FAIL drop_busy: got %b, required 1", busy); n_err++; end
    send_beat(8'h11, 1'b1, hs);
    send_beat(8'h2A, 1'b1, hs);
    idle(4);
    n_vec++;
    if (wr_addr_q.size() != 0) begin
      $display("FAIL err_no_write: got %0d writes, required 0", wr_addr_q.size()); n_err++;
    end
    n_vec++;
    if (busy !== 1'b0) begin $display("FAIL err_busy: got %b, required 0", busy); n_err++; end
    n_vec++;
    if (addr !== 7'h10) begin $display("FAIL err_addr_hold: got 0x%h, required 0x10", addr); n_err++; end
`ifdef AXIS_I2C_CMD_ERRCNT_EN
    n_vec++;
    if (err_cnt !== 16'd2) begin $display("FAIL err_cnt: got %0d, required 2", err_cnt); n_err++; end
`endif
  endtask

  task automatic test_reset_mid_packet();
    int hs;
    logic bad_addr;
    clear_log();
    send_beat(8'h12, 1'b0, hs);
    send_beat(8'h34, 1'b0, hs);
    arst          = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    arst = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || addr !== 7'h00) begin
      $display("FAIL mid_reset_state: got busy=%b addr=0x%h, required busy=0 addr=0x00", busy, addr); n_err++;
    end
    send_beat(8'h22, 1'b0, hs);
    send_beat(8'h77, 1'b1, hs);
    idle(4);
    bad_addr = 1'b0;
    foreach (wr_addr_q[i]) if (wr_addr_q[i] === 7'h12) bad_addr = 1'b1;
    n_vec++;
    if (bad_addr !== 1'b0) begin $display("FAIL mid_abandon: got a write with addr 0x12, required none"); n_err++; end
    n_vec++;
    if (wr_addr_q.size() != 1) begin
      $display("FAIL mid_count: got %0d writes, required 1", wr_addr_q.size()); n_err++;
    end else begin
      n_vec++;
      if (wr_addr_q[0] !== 7'h22 || wr_data_q[0] !== 8'h77) begin
        $display("FAIL mid_write: got addr=0x%h data=0x%h, required addr=0x22 data=0x77",
                 wr_addr_q[0], wr_data_q[0]);
        n_err++;
      end
    end
  endtask

  initial begin
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    fifo_full     = 1'b0;
    arst          = 1'b1;
    #1;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axis_i2c_cmd.md
AXIS_I2C_CMD -- requirements
Module: axis_i2c_cmd

Interface
REQ-001 SHALL have parameter DATA_W, default 8: I2C payload byte width and s_axis_tdata width.
REQ-002 SHALL have parameter ADDR_W, default 7: I2C slave address width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port arst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port s_axis_tdata, input, DATA_W: stream byte.
REQ-006 SHALL have port s_axis_tvalid, input, 1: beat valid.
REQ-007 SHALL have port s_axis_tlast, input, 1: last beat of packet.
REQ-008 SHALL have port s_axis_tready, output, 1: beat accepted when tvalid and tready are both high.
REQ-009 SHALL have port addr, output, ADDR_W: slave address to i2c_master.
REQ-010 SHALL have port data, output, DATA_W: payload byte to i2c_master.
REQ-011 SHALL have port fifo_wr_en, output, 1: one-cycle push into the i2c_master command FIFO.
REQ-012 SHALL have port fifo_full, input, 1: i2c_master command FIFO full.
REQ-013 SHALL have port busy, output, 1: high while the state is not S_ADDR.

Function
REQ-014 SHALL implement three states: S_ADDR (expect address beat), S_DATA (expect payload beats), S_DROP (discard until tlast).
REQ-015 S_ADDR SHALL drive tready=1.
REQ-016 S_ADDR accept with tdata[DATA_W-1:ADDR_W]==0 and tlast=0 SHALL latch tdata[ADDR_W-1:0] into addr and go to S_DATA.
REQ-017 S_ADDR accept with nonzero upper bits and tlast=0 SHALL go to S_DROP; addr SHALL be unchanged.
REQ-018 S_ADDR accept with tlast=1 (address-only packet) SHALL stay in S_ADDR, produce no write and count as an error.
REQ-019 S_DATA SHALL drive tready = !fifo_full && !fifo_wr_en, giving at most one command per two cycles.
REQ-020 S_DATA accept SHALL register tdata into data and pulse fifo_wr_en high for exactly the next cycle (latency 1).
REQ-021 S_DATA accept with tlast=1 SHALL return to S_ADDR after issuing that write.
REQ-022 S_DROP SHALL drive tready=1, produce no writes, and return to S_ADDR on an accepted tlast.
REQ-023 fifo_wr_en SHALL never assert in a cycle that follows a cycle with fifo_full=1.
REQ-024 addr SHALL remain stable for every write of a packet; data SHALL hold between writes.
REQ-025 tvalid low in any state SHALL cause no state change and no write.

Reset
REQ-026 arst=1 SHALL, at the next edge, set the state to S_ADDR, addr=0, data=0, fifo_wr_en=0, busy=0 and (when compiled in) err_cnt=0.
REQ-027 arst=1 mid-packet SHALL abandon the packet: no write issued, and the next accepted beat is treated as an address.
REQ-028 tready SHALL be 0 while arst=1.

Configuration
REQ-029 With macro AXIS_I2C_CMD_ERRCNT_EN defined, the block SHALL add output err_cnt (16 bits); err_cnt SHALL increment, saturating at 0xFFFF, on each REQ-017 or REQ-018 event.
REQ-030 Without AXIS_I2C_CMD_ERRCNT_EN, the err_cnt port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package axis_i2c_pkg SHALL hold ADDR_W=7, DATA_W=8, CMD_W=ADDR_W+DATA_W (15, the i2c_master FIFO word) and the state enum.
REQ-032 The block SHALL be a single module with no sub-module; the command FIFO remains inside i2c_master.

Verification
REQ-033 Reset, then packet 0x50, 0xA5 (tlast) -> exactly one fifo_wr_en pulse with addr=0x50, data=0xA5, one cycle after the 0xA5 handshake; busy returns to 0.
REQ-034 Packet 0x3C, 0x01, 0x02, 0x03 (tlast), tvalid held high -> three pulses with data 0x01/0x02/0x03, addr=0x3C, pulses separated by one idle cycle.
REQ-035 Hold fifo_full=1 during the S_DATA phase -> tready=0 and no pulse; release fifo_full -> write resumes on the next accepted beat.
REQ-036 Packet 0x80, 0x11 (tlast), then 0x2A (tlast) -> no writes; err_cnt=2 with AXIS_I2C_CMD_ERRCNT_EN defined, port absent without it.
REQ-037 Assert arst after beats 0x12, 0x34 of an unfinished packet, then send 0x22, 0x77 (tlast) -> single write addr=0x22, data=0x77; no write carries addr 0x12.
